fft_frame_sequencer: RTL and testbench
======================================

FFT_FRAME_SEQUENCER -- requirements
Module: fft_frame_sequencer

Interface
REQ-001 SHALL have parameter N, default 1024: FFT frame length in complex samples (power of 2).
REQ-002 SHALL have parameter MAX_INFLIGHT, default 2: maximum number of frames accepted but not yet completed at the pipeline output.
REQ-003 SHALL have port i_clk, input, 1 bit: single clock; all logic is rising-edge.
REQ-004 SHALL have port i_reset, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port i_enable, input, 1 bit: permits starting a new frame.
REQ-006 SHALL have port i_s_valid, input, 1 bit: upstream sample valid.
REQ-007 SHALL have port o_s_ready, output, 1 bit: upstream ready; a transfer occurs when i_s_valid and o_s_ready are both 1.
REQ-008 SHALL have ports i_s_real and i_s_imag, input, 32 bits each: upstream sample.
REQ-009 SHALL have port i_s_last, input, 1 bit: upstream marker for the last sample of a frame.
REQ-010 SHALL have port o_valid_in, output, 1 bit: pair strobe to the first pipeline stage.
REQ-011 SHALL have ports o_data_a_real, o_data_a_imag, o_data_b_real and o_data_b_imag, output, 32 bits each: butterfly pair to the first stage.
REQ-012 SHALL have port i_valid_out, input, 1 bit: final-stage output pair strobe.
REQ-013 SHALL have port o_frame_done, output, 1 bit: one-cycle pulse when a frame completes at the output.
REQ-014 SHALL have port o_frame_cnt, output, 16 bits: count of completed frames; wraps 0xFFFF->0.
REQ-015 SHALL have port o_inflight, output, 2 bits: number of frames currently in flight.
REQ-016 SHALL have port o_busy, output, 1 bit: high when state != IDLE or o_inflight != 0.
REQ-017 SHALL have port o_err_last, output, 1 bit: sticky flag for a framing error.
REQ-018 SHALL have port o_err_spur, output, 1 bit: sticky flag for a spurious output strobe.
REQ-019 SHALL have port i_err_clr, input, 1 bit: clears both sticky flags.

Function
REQ-020 SHALL implement FSM states IDLE, FILL and PAIR, with a sample index idx of log2(N) bits.
REQ-021 IDLE: o_s_ready=0; the FSM SHALL go to FILL on the next edge when i_enable=1 and o_inflight<MAX_INFLIGHT.
REQ-022 FILL: o_s_ready=1; each transfer SHALL write the sample to half-frame buffer entry idx (N/2 x 64 bits) and increment idx; a transfer at idx=N/2-1 SHALL move the FSM to PAIR.
REQ-023 PAIR: o_s_ready=1; a transfer at idx=N/2+k SHALL, one cycle later, drive o_valid_in=1 with A=buf[k] and B=the accepted sample.
REQ-024 o_valid_in SHALL be high for exactly one cycle per PAIR transfer, with no backpressure from the pipeline.
REQ-025 A transfer at idx=N-1 SHALL wrap idx to 0 and return the FSM to IDLE, giving a fixed one-cycle bubble between frames.
REQ-026 Data outputs SHALL be registered and SHALL hold their last value while o_valid_in=0.
REQ-027 o_inflight SHALL increment on the transfer at idx=0 and decrement when the output pair counter reaches N/2; simultaneous increment and decrement SHALL leave it unchanged.
REQ-028 The output pair counter SHALL count i_valid_out strobes while o_inflight>0 and wrap at N/2; the N/2-th strobe SHALL pulse o_frame_done for one cycle in the following cycle and increment o_frame_cnt.
REQ-029 An i_valid_out strobe while o_inflight=0 SHALL set o_err_spur and SHALL NOT change any counter.
REQ-030 o_err_last SHALL be set if i_s_last=1 on a transfer with idx!=N-1, or if i_s_last=0 on a transfer with idx=N-1.
REQ-031 Framing errors SHALL NOT alter sequencing; the frame always completes at N samples.
REQ-032 i_err_clr SHALL clear both sticky flags; a new error in the same cycle SHALL win, leaving the flag set.
REQ-033 i_enable=0 during FILL or PAIR SHALL NOT abort the frame; it SHALL only block the IDLE->FILL transition.

Reset
REQ-034 On i_reset=0, state SHALL be IDLE, idx, counters and o_inflight SHALL be 0, and all outputs, data outputs, pulses and flags SHALL be 0.
REQ-035 A partial frame SHALL be discarded on reset; buffer contents are not reset and are don't-care.
REQ-036 Outputs SHALL return to their reset values asynchronously on i_reset assertion; release of reset is synchronous to i_clk.

Verification
REQ-037 N=1024, one frame streamed with sample n=(n,-n), last at n=1023 -> 512 o_valid_in pulses, pair k is A=(k,-k), B=(k+512,-(k+512)); each pulse arrives one cycle after its source transfer.
REQ-038 Three frames back-to-back with MAX_INFLIGHT=2 and no i_valid_out -> o_s_ready stays 0 in IDLE after frame 2 and o_inflight=2; 512 i_valid_out strobes -> o_frame_done pulses, o_inflight=1, frame 3 is accepted.
REQ-039 i_s_last asserted at idx=700 -> o_err_last=1 and the frame still emits 512 pairs; i_err_clr -> o_err_last=0.
REQ-040 i_valid_out pulsed with o_inflight=0 -> o_err_spur=1 and o_frame_cnt unchanged.
REQ-041 Reset asserted at idx=600 -> all outputs 0 immediately; after release a full frame produces pairs identical to REQ-037.
REQ-042 o_frame_cnt preloaded near wrap through 65536 completions (or a forced counter) -> 0xFFFF->0x0000 wrap; o_frame_done pulse coincides with the final i_valid_out plus one cycle.

Source files
------------

// File: rtl/fft_frame_sequencer.sv
// rtl/fft_frame_sequencer.sv - streams frames into a radix-2 FFT front stage and tracks frames in flight
// First half of each frame is buffered, second half is paired with it as butterfly inputs.
module fft_frame_sequencer #(
    parameter int N            = 1024,
    parameter int MAX_INFLIGHT = 2
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_enable,
    input  logic        i_s_valid,
    output logic        o_s_ready,
    input  logic [31:0] i_s_real,
    input  logic [31:0] i_s_imag,
    input  logic        i_s_last,
    output logic        o_valid_in,
    output logic [31:0] o_data_a_real,
    output logic [31:0] o_data_a_imag,
    output logic [31:0] o_data_b_real,
    output logic [31:0] o_data_b_imag,
    input  logic        i_valid_out,
    output logic        o_frame_done,
    output logic [15:0] o_frame_cnt,
    output logic [1:0]  o_inflight,
    output logic        o_busy,
    output logic        o_err_last,
    output logic        o_err_spur,
    input  logic        i_err_clr
);
    localparam int IW   = $clog2(N);
    localparam int HW   = IW - 1;
    localparam int HALF = N / 2;

    typedef enum logic [1:0] {IDLE, FILL, PAIR} state_t;

    state_t         state_q, state_d;
    logic [IW-1:0]  idx_q, idx_d;
    logic [HW-1:0]  pair_cnt_q, pair_cnt_d;
    logic [1:0]     inflight_q, inflight_d;
    logic [15:0]    frame_cnt_q, frame_cnt_d;
    logic           done_q, done_d;
    logic           valid_q, valid_d;
    logic [63:0]    a_q, a_d;
    logic [63:0]    b_q, b_d;
    logic           err_last_q, err_last_d;
    logic           err_spur_q, err_spur_d;

    logic [63:0]    half_buf [HALF];

    logic           xfer;
    logic           inc;
    logic           strobe_ok;
    logic           frame_end;

    assign xfer      = i_s_valid && (state_q != IDLE);
    assign inc       = xfer && (idx_q == '0);
    assign strobe_ok = i_valid_out && (inflight_q != 2'd0);
    assign frame_end = strobe_ok && (pair_cnt_q == HW'(HALF - 1));

    // Buffer holds raw samples only; no reset so it maps onto plain RAM.
    always_ff @(posedge i_clk) begin
        if (xfer && state_q == FILL) begin
            half_buf[idx_q[HW-1:0]] <= {i_s_real, i_s_imag};
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        valid_d = 1'b0;
        a_d     = a_q;
        b_d     = b_q;
        case (state_q)
            IDLE: begin
                if (i_enable && (int'(inflight_q) < MAX_INFLIGHT)) begin
                    state_d = FILL;
                end
            end
            FILL: begin
                if (xfer) begin
                    idx_d = idx_q + IW'(1);
                    if (idx_q == IW'(HALF - 1)) begin
                        state_d = PAIR;
                    end
                end
            end
            PAIR: begin
                if (xfer) begin
                    idx_d   = idx_q + IW'(1);
                    valid_d = 1'b1;
                    a_d     = half_buf[idx_q[HW-1:0]];
                    b_d     = {i_s_real, i_s_imag};
                    if (idx_q == IW'(N - 1)) begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Output side: pair counting, frame completion and in-flight bookkeeping.
    always_comb begin
        pair_cnt_d  = pair_cnt_q;
        frame_cnt_d = frame_cnt_q;
        done_d      = frame_end;
        inflight_d  = inflight_q;
        if (strobe_ok) begin
            pair_cnt_d = pair_cnt_q + HW'(1);
        end
        if (frame_end) begin
            frame_cnt_d = frame_cnt_q + 16'd1;
        end
        case ({inc, frame_end})
            2'b10:   inflight_d = inflight_q + 2'd1;
            2'b01:   inflight_d = inflight_q - 2'd1;
            default: inflight_d = inflight_q;
        endcase
    end

    // A new error in the clearing cycle leaves the flag set.
    always_comb begin
        err_last_d = (err_last_q && !i_err_clr) ||
                     (xfer && (i_s_last != (idx_q == IW'(N - 1))));
        err_spur_d = (err_spur_q && !i_err_clr) ||
                     (i_valid_out && (inflight_q == 2'd0));
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            pair_cnt_q  <= '0;
            inflight_q  <= '0;
            frame_cnt_q <= '0;
            done_q      <= 1'b0;
            valid_q     <= 1'b0;
            a_q         <= '0;
            b_q         <= '0;
            err_last_q  <= 1'b0;
            err_spur_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            pair_cnt_q  <= pair_cnt_d;
            inflight_q  <= inflight_d;
            frame_cnt_q <= frame_cnt_d;
            done_q      <= done_d;
            valid_q     <= valid_d;
            a_q         <= a_d;
            b_q         <= b_d;
            err_last_q  <= err_last_d;
            err_spur_q  <= err_spur_d;
        end
    end

    assign o_s_ready     = (state_q != IDLE);
    assign o_valid_in    = valid_q;
    assign o_data_a_real = a_q[63:32];
    assign o_data_a_imag = a_q[31:0];
    assign o_data_b_real = b_q[63:32];
    assign o_data_b_imag = b_q[31:0];
    assign o_frame_done  = done_q;
    assign o_frame_cnt   = frame_cnt_q;
    assign o_inflight    = inflight_q;
    assign o_busy        = (state_q != IDLE) || (inflight_q != 2'd0);
    assign o_err_last    = err_last_q;
    assign o_err_spur    = err_spur_q;

endmodule

// File: tb/tb_fft_frame_sequencer.sv
// tb/tb_fft_frame_sequencer.sv - randomized bench with a frame-level reference model for fft_frame_sequencer
module tb_fft_frame_sequencer;
    localparam int N    = 1024;
    localparam int HALF = N / 2;
    localparam int MAXF = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        i_enable = 1'b0;
    logic        i_s_valid = 1'b0;
    logic        o_s_ready;
    logic [31:0] i_s_real = '0;
    logic [31:0] i_s_imag = '0;
    logic        i_s_last = 1'b0;
    logic        o_valid_in;
    logic [31:0] o_data_a_real, o_data_a_imag, o_data_b_real, o_data_b_imag;
    logic        i_valid_out = 1'b0;
    logic        o_frame_done;
    logic [15:0] o_frame_cnt;
    logic [1:0]  o_inflight;
    logic        o_busy;
    logic        o_err_last;
    logic        o_err_spur;
    logic        i_err_clr = 1'b0;

    always #5 clk = ~clk;

    fft_frame_sequencer #(.N(N), .MAX_INFLIGHT(MAXF)) dut (
        .i_clk(clk), .i_reset(rst_n), .i_enable(i_enable),
        .i_s_valid(i_s_valid), .o_s_ready(o_s_ready),
        .i_s_real(i_s_real), .i_s_imag(i_s_imag), .i_s_last(i_s_last),
        .o_valid_in(o_valid_in),
        .o_data_a_real(o_data_a_real), .o_data_a_imag(o_data_a_imag),
        .o_data_b_real(o_data_b_real), .o_data_b_imag(o_data_b_imag),
        .i_valid_out(i_valid_out), .o_frame_done(o_frame_done),
        .o_frame_cnt(o_frame_cnt), .o_inflight(o_inflight), .o_busy(o_busy),
        .o_err_last(o_err_last), .o_err_spur(o_err_spur), .i_err_clr(i_err_clr)
    );

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic timeout(input string name);
        checks++;
        errors++;
        $display("FAIL %s: wait bound expired at %0t", name, $time);
    endtask

    // Reference model: a frame is a position counter; pairs come from a stored first half.
    bit          m_active = 0;
    int          m_pos = 0;
    int          m_inflight = 0;
    int          m_pairs = 0;
    logic [15:0] m_cnt = '0;
    bit          m_done = 0, m_valid = 0, m_el = 0, m_es = 0;
    logic [63:0] m_a = '0, m_b = '0;
    logic [63:0] m_half [HALF];
    bit          t_xfer, t_inc, t_dec;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_active = 0; m_pos = 0; m_inflight = 0; m_pairs = 0; m_cnt = '0;
            m_done = 0; m_valid = 0; m_el = 0; m_es = 0; m_a = '0; m_b = '0;
        end else begin
            t_xfer = i_s_valid && m_active;
            t_inc = 0;
            t_dec = 0;
            m_valid = 0;
            m_done = 0;
            if (i_err_clr) begin
                m_el = 0;
                m_es = 0;
            end
            if (!m_active) begin
                if (i_enable && m_inflight < MAXF) m_active = 1;
            end else if (t_xfer) begin
                if (i_s_last != (m_pos == N - 1)) m_el = 1;
                if (m_pos == 0) t_inc = 1;
                if (m_pos < HALF) begin
                    m_half[m_pos] = {i_s_real, i_s_imag};
                end else begin
                    m_valid = 1;
                    m_a = m_half[m_pos - HALF];
                    m_b = {i_s_real, i_s_imag};
                end
                m_pos++;
                if (m_pos == N) begin
                    m_pos = 0;
                    m_active = 0;
                end
            end
            if (i_valid_out) begin
                if (m_inflight == 0) begin
                    m_es = 1;
                end else begin
                    m_pairs++;
                    if (m_pairs == HALF) begin
                        m_pairs = 0;
                        m_done = 1;
                        m_cnt = m_cnt + 16'd1;
                        t_dec = 1;
                    end
                end
            end
            m_inflight = m_inflight + int'(t_inc) - int'(t_dec);
        end
    end

    logic [63:0] pa[$];
    logic [63:0] pb[$];
    int          n_done = 0;
    time         t_done = 0;
    time         t_strobe = 0;

    always @(negedge clk) begin
        chk("s_ready",    64'(o_s_ready),    64'(m_active));
        chk("valid_in",   64'(o_valid_in),   64'(m_valid));
        chk("data_a",     {o_data_a_real, o_data_a_imag}, m_a);
        chk("data_b",     {o_data_b_real, o_data_b_imag}, m_b);
        chk("frame_done", 64'(o_frame_done), 64'(m_done));
        chk("frame_cnt",  64'(o_frame_cnt),  64'(m_cnt));
        chk("inflight",   64'(o_inflight),   64'(m_inflight));
        chk("busy",       64'(o_busy),       64'(m_active || m_inflight != 0));
        chk("err_last",   64'(o_err_last),   64'(m_el));
        chk("err_spur",   64'(o_err_spur),   64'(m_es));
        if (o_valid_in) begin
            pa.push_back({o_data_a_real, o_data_a_imag});
            pb.push_back({o_data_b_real, o_data_b_imag});
        end
        if (o_frame_done) begin
            n_done++;
            t_done = $time;
        end
    end

    task automatic send_frame(input int nsamp, input int last_at, input bit rnd);
        int n = 0;
        int guard = 0;
        bit rdy;
        while (n < nsamp) begin
            @(negedge clk);
            i_s_valid = ($urandom_range(0, 3) != 0);
            if (rnd) begin
                i_s_real = $urandom;
                i_s_imag = $urandom;
            end else begin
                i_s_real = n;
                i_s_imag = -n;
            end
            i_s_last = (n == last_at);
            i_enable = (n == 0) ? 1'b1 : 1'($urandom_range(0, 1));
            rdy = o_s_ready;
            @(posedge clk);
            if (i_s_valid && rdy) n++;
            guard++;
            if (guard > 20 * N) begin
                timeout("send_frame");
                break;
            end
        end
        @(negedge clk);
        i_s_valid = 0;
        i_s_last = 0;
        i_enable = 1;
    endtask

    task automatic strobe(input int cnt);
        int i = 0;
        int guard = 0;
        while (i < cnt) begin
            @(negedge clk);
            i_valid_out = ($urandom_range(0, 2) != 0);
            @(posedge clk);
            if (i_valid_out) begin
                i++;
                t_strobe = $time;
            end
            guard++;
            if (guard > 20 * N) begin
                timeout("strobe");
                break;
            end
        end
        @(negedge clk);
        i_valid_out = 0;
    endtask

    task automatic check_ref_pairs(input string tag);
        logic [31:0] kr, ki, br, bi;
        chk({tag, "_npairs"}, 64'(pa.size()), 64'(HALF));
        for (int k = 0; k < pa.size() && k < HALF; k++) begin
            kr = k;
            ki = -k;
            br = k + HALF;
            bi = -(k + HALF);
            chk({tag, "_pair_a"}, pa[k], {kr, ki});
            chk({tag, "_pair_b"}, pb[k], {br, bi});
        end
    endtask

    initial begin
        #2_000_000;
        timeout("global_watchdog");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_ready", 64'(o_s_ready), 64'd0);
        chk("rst_cnt", 64'(o_frame_cnt), 64'd0);
        chk("rst_busy", 64'(o_busy), 64'd0);
        chk("rst_data", {o_data_b_real, o_data_b_imag}, 64'd0);
        rst_n = 1;
        i_enable = 1;

        // Single frame with the reference pattern.
        pa.delete(); pb.delete();
        send_frame(N, N - 1, 0);
        repeat (2) @(negedge clk);
        check_ref_pairs("single");
        chk("single_inflight", 64'(o_inflight), 64'd1);
        strobe(HALF);
        repeat (2) @(negedge clk);
        chk("single_cnt", 64'(o_frame_cnt), 64'd1);
        chk("single_ndone", 64'(n_done), 64'd1);

        // In-flight limit blocks the third frame until one completes.
        send_frame(N, N - 1, 1);
        send_frame(N, N - 1, 1);
        repeat (20) @(negedge clk);
        chk("limit_inflight", 64'(o_inflight), 64'd2);
        chk("limit_ready", 64'(o_s_ready), 64'd0);
        fork
            send_frame(N, N - 1, 1);
            begin
                repeat (50) @(negedge clk);
                strobe(HALF);
            end
        join
        repeat (2) @(negedge clk);
        chk("limit_cnt", 64'(o_frame_cnt), 64'd2);
        chk("limit_inflight_after", 64'(o_inflight), 64'd2);
        strobe(N);
        repeat (2) @(negedge clk);
        chk("drain_cnt", 64'(o_frame_cnt), 64'd4);
        chk("drain_inflight", 64'(o_inflight), 64'd0);

        // Early last marker flags an error but the frame still runs to N samples.
        pa.delete(); pb.delete();
        send_frame(N, 700, 0);
        repeat (2) @(negedge clk);
        chk("early_last_flag", 64'(o_err_last), 64'd1);
        check_ref_pairs("early_last");
        i_err_clr = 1;
        @(negedge clk);
        i_err_clr = 0;
        chk("early_last_clr", 64'(o_err_last), 64'd0);
        strobe(HALF);
        repeat (2) @(negedge clk);

        // Spurious output strobe.
        i_valid_out = 1;
        @(negedge clk);
        i_valid_out = 0;
        chk("spur_flag", 64'(o_err_spur), 64'd1);
        chk("spur_cnt", 64'(o_frame_cnt), 64'd5);
        i_err_clr = 1;
        @(negedge clk);
        i_err_clr = 0;

        // Reset in the middle of a frame.
        send_frame(600, N - 1, 0);
        @(posedge clk);
        #2 rst_n = 0;
        #1;
        chk("arst_ready", 64'(o_s_ready), 64'd0);
        chk("arst_valid", 64'(o_valid_in), 64'd0);
        chk("arst_data_a", {o_data_a_real, o_data_a_imag}, 64'd0);
        chk("arst_inflight", 64'(o_inflight), 64'd0);
        chk("arst_busy", 64'(o_busy), 64'd0);
        chk("arst_cnt", 64'(o_frame_cnt), 64'd0);
        @(negedge clk);
        rst_n = 1;
        pa.delete(); pb.delete();
        send_frame(N, N - 1, 0);
        repeat (2) @(negedge clk);
        check_ref_pairs("post_reset");
        strobe(HALF);
        repeat (2) @(negedge clk);
        chk("post_reset_cnt", 64'(o_frame_cnt), 64'd1);

        // Completion counter wrap from a preloaded value.
        @(posedge clk);
        #2;
        force dut.frame_cnt_q = 16'hFFFE;
        m_cnt = 16'hFFFE;
        #1 release dut.frame_cnt_q;
        send_frame(N, N - 1, 1);
        strobe(HALF);
        repeat (2) @(negedge clk);
        chk("wrap_ffff", 64'(o_frame_cnt), 64'hFFFF);
        send_frame(N, N - 1, 1);
        strobe(HALF);
        repeat (2) @(negedge clk);
        chk("wrap_zero", 64'(o_frame_cnt), 64'h0000);
        chk("wrap_done_timing", 64'(t_done), 64'(t_strobe + 5));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
